// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for four requesters sharing one tri-state bus.
// Each grant drives the bus for at most max_burst cycles. A fixed number
// of idle turnaround cycles, with every output enable low, separates two
// owners so that no two drivers ever overlap on the wire.
module tri_bus_arbiter #(
  parameter int width      = 1,
  parameter int turnaround = 1,
  parameter int max_burst  = 16
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [3:0]         REQ,
  input  logic [4*width-1:0] DIN,
  output logic [3:0]         GRANT,
  output logic [3:0]         OE,
  output logic [width-1:0]   BUS_DOUT,
  output logic               BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam logic [7:0] LP_MAX_BURST  = 8'(max_burst);
  localparam logic [3:0] LP_TURNAROUND = 4'(turnaround);

  state_t     r_state, w_stateNext;
  logic [1:0] r_ptr, w_ptrNext;
  logic [1:0] r_owner, w_ownerNext;
  logic [7:0] r_bcnt, w_bcntNext;
  logic [3:0] r_tcnt, w_tcntNext;
  logic [3:0] r_grant, w_grantNext;
  logic       w_selValid;
  logic [1:0] w_selIdx;
  logic       w_release;

  // Round-robin search starting at the pointer. The loop runs from the
  // farthest offset down, so the closest active requester is written last.
  always_comb begin
    w_selValid = 1'b0;
    w_selIdx   = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (REQ[r_ptr + 2'(i)]) begin
        w_selValid = 1'b1;
        w_selIdx   = r_ptr + 2'(i);
      end
    end
  end

  // The owner lets go when its request drops or its burst is used up.
  // If both happen on the same edge, it still counts as one release.
  always_comb begin
    w_release = !REQ[r_owner] || (r_bcnt == LP_MAX_BURST);
  end

  // Next-state logic. New grants come only from IDLE or from the last
  // turnaround cycle. While the bus is owned or turning around, requests
  // from other requesters are ignored.
  always_comb begin
    w_stateNext = r_state;
    w_ptrNext   = r_ptr;
    w_ownerNext = r_owner;
    w_bcntNext  = r_bcnt;
    w_tcntNext  = r_tcnt;
    w_grantNext = r_grant;
    case (r_state)
      ST_IDLE: begin
        if (w_selValid) begin
          w_stateNext = ST_DRIVE;
          w_ownerNext = w_selIdx;
          w_grantNext = 4'b0001 << w_selIdx;
          w_bcntNext  = 8'd1;
        end
      end
      ST_DRIVE: begin
        if (w_release) begin
          w_stateNext = ST_TURN;
          w_grantNext = 4'b0000;
          w_tcntNext  = LP_TURNAROUND;
          w_ptrNext   = r_owner + 2'd1;
        end else begin
          w_bcntNext = r_bcnt + 8'd1;
        end
      end
      ST_TURN: begin
        if (r_tcnt <= 4'd1) begin
          w_tcntNext = 4'd0;
          if (w_selValid) begin
            w_stateNext = ST_DRIVE;
            w_ownerNext = w_selIdx;
            w_grantNext = 4'b0001 << w_selIdx;
            w_bcntNext  = 8'd1;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end else begin
          w_tcntNext = r_tcnt - 4'd1;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_grantNext = 4'b0000;
      end
    endcase
  end

  // State register. Reset clears the grant at once, so the bus drivers
  // stop immediately without waiting for a turnaround.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_bcnt  <= 8'd0;
      r_tcnt  <= 4'd0;
      r_grant <= 4'b0000;
    end else begin
      r_state <= w_stateNext;
      r_ptr   <= w_ptrNext;
      r_owner <= w_ownerNext;
      r_bcnt  <= w_bcntNext;
      r_tcnt  <= w_tcntNext;
      r_grant <= w_grantNext;
    end
  end

  // The bus mux is driven straight from the registered grant, with no data
  // register in the path. It reads all zeros when nobody owns the bus.
  always_comb begin
    BUS_DOUT = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_grant[k]) begin
        BUS_DOUT = BUS_DOUT | DIN[k*width +: width];
      end
    end
  end

  assign GRANT = r_grant;
  assign OE    = r_grant;
  assign BUSY  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Bench for tri_bus_arbiter. Two instances share the same stimulus, each
// with different turnaround and burst limits. Both are checked against a
// behavioural owner/gap model, fixed vector tables, hand-written corner
// sequences, and a per-cycle monitor of the output enables.
module tb_tri_bus_arbiter;

  localparam int W    = 8;
  localparam int TA_A = 1;
  localparam int MB_A = 4;
  localparam int TA_B = 2;
  localparam int MB_B = 3;

  logic         CLK;
  logic         RST_N;
  logic [3:0]   REQ;
  logic [4*W-1:0] DIN;
  logic [3:0]   grantA, oeA, grantB, oeB;
  logic [W-1:0] doutA, doutB;
  logic         busyA, busyB;

  int checks   = 0;
  int failures = 0;

  tri_bus_arbiter #(.width(W), .turnaround(TA_A), .max_burst(MB_A)) dutA (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DIN(DIN),
    .GRANT(grantA), .OE(oeA), .BUS_DOUT(doutA), .BUSY(busyA)
  );

  tri_bus_arbiter #(.width(W), .turnaround(TA_B), .max_burst(MB_B)) dutB (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .DIN(DIN),
    .GRANT(grantB), .OE(oeB), .BUS_DOUT(doutB), .BUSY(busyB)
  );

  // Free-running clock, period 10.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural view of the bus: who owns it (-1 for nobody), how many
  // cycles it has been held, how many silent cycles are still owed, and
  // who gets priority next.
  typedef struct {
    int owner;
    int held;
    int gap;
    int prio;
  } model_t;

  model_t mA, mB;

  typedef struct {
    bit         rstBefore;
    logic [3:0] req;
    logic [3:0] expA;
    logic [3:0] expB;
  } vec_t;

  vec_t vecs[$];

  function automatic model_t modelReset();
    model_t m;
    m.owner = -1;
    m.held  = 0;
    m.gap   = 0;
    m.prio  = 0;
    return m;
  endfunction

  function automatic int pickNext(logic [3:0] req, int prio);
    for (int off = 0; off < 4; off++) begin
      if (req[(prio + off) % 4]) return (prio + off) % 4;
    end
    return -1;
  endfunction

  function automatic model_t modelStep(model_t m, logic [3:0] req, int ta, int mb);
    model_t n = m;
    if (m.owner >= 0) begin
      if (!req[m.owner] || m.held == mb) begin
        n.owner = -1;
        n.held  = 0;
        n.gap   = ta;
        n.prio  = (m.owner + 1) % 4;
      end else begin
        n.held = m.held + 1;
      end
    end else if (m.gap > 1) begin
      n.gap = m.gap - 1;
    end else begin
      n.gap   = 0;
      n.owner = pickNext(req, m.prio);
      n.held  = (n.owner >= 0) ? 1 : 0;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareOne(input string tag, input model_t m, input logic [3:0] g,
                            input logic [3:0] oe, input logic busy, input logic [W-1:0] dout);
    logic [3:0]   expG;
    logic [W-1:0] expD;
    expG = (m.owner >= 0) ? 4'(1 << m.owner) : 4'b0000;
    expD = (m.owner >= 0) ? DIN[m.owner*W +: W] : '0;
    checkOutput({tag, ".grant"}, 32'(g), 32'(expG));
    checkOutput({tag, ".oe"}, 32'(oe), 32'(expG));
    checkOutput({tag, ".busy"}, 32'(busy), 32'((m.owner >= 0) || (m.gap > 0)));
    checkOutput({tag, ".dout"}, 32'(dout), 32'(expD));
  endtask

  task automatic compareModels();
    compareOne("A", mA, grantA, oeA, busyA, doutA);
    compareOne("B", mB, grantB, oeB, busyB, doutB);
  endtask

  // One clock cycle: drive the inputs, let an edge pass, advance the
  // model, then compare the outputs.
  task automatic applyStimulus(input logic [3:0] req, input logic [4*W-1:0] din);
    REQ = req;
    DIN = din;
    @(posedge CLK);
    mA = modelStep(mA, req, TA_A, MB_A);
    mB = modelStep(mB, req, TA_B, MB_B);
    #1;
    compareModels();
  endtask

  task automatic applyReset();
    RST_N = 1'b0;
    REQ   = 4'b0000;
    mA    = modelReset();
    mB    = modelReset();
    @(posedge CLK);
    #1;
    checkOutput("rst.grantA", 32'(grantA), 32'h0);
    checkOutput("rst.oeB", 32'(oeB), 32'h0);
    checkOutput("rst.busyA", 32'(busyA), 32'h0);
    checkOutput("rst.doutB", 32'(doutB), 32'h0);
    RST_N = 1'b1;
  endtask

  // Output-enable monitor. Only one enable may be high at a time. Whenever
  // the bus is handed over, or the same owner is granted again after a
  // break, there must be at least the turnaround count of all-zero cycles.
  int         zeroRun [2];
  logic [3:0] lastOe  [2];
  logic [3:0] oeNow   [2];
  int         gapTa   [2];

  initial begin
    gapTa[0] = TA_A;
    gapTa[1] = TA_B;
  end

  always @(negedge CLK) begin
    oeNow[0] = oeA;
    oeNow[1] = oeB;
    for (int d = 0; d < 2; d++) begin
      if (!RST_N) begin
        lastOe[d]  = 4'b0000;
        zeroRun[d] = 0;
      end else if (oeNow[d] == 4'b0000) begin
        zeroRun[d]++;
      end else begin
        checkOutput("mon.onehot", 32'($onehot(oeNow[d])), 32'd1);
        if (lastOe[d] != 4'b0000 && (oeNow[d] != lastOe[d] || zeroRun[d] != 0))
          checkOutput("mon.gap", 32'(zeroRun[d] >= gapTa[d]), 32'd1);
        lastOe[d]  = oeNow[d];
        zeroRun[d] = 0;
      end
    end
  end

  initial begin
    vec_t       v;
    logic [3:0] rq;
    logic [4*W-1:0] din0;

    RST_N = 1'b0;
    REQ   = 4'b0000;
    DIN   = '0;
    mA    = modelReset();
    mB    = modelReset();

    // Vector tables built from the expected rotation pattern. With every
    // requester active, A grants owners 0,1,2,3 for 4 cycles each, then
    // 1 idle cycle. B grants each owner for 3 cycles, then 2 idle cycles.
    // With only requester 1 active, the pattern repeats on owner 1.
    for (int c = 1; c <= 24; c++) begin
      int pos;
      int own;
      pos = (c - 1) % 5;
      own = ((c - 1) / 5) % 4;
      v.rstBefore = (c == 1);
      v.req  = 4'b1111;
      v.expA = (pos < 4) ? 4'(1 << own) : 4'b0000;
      v.expB = (pos < 3) ? 4'(1 << own) : 4'b0000;
      vecs.push_back(v);
    end
    for (int c = 1; c <= 15; c++) begin
      int pos;
      pos = (c - 1) % 5;
      v.rstBefore = (c == 1);
      v.req  = 4'b0010;
      v.expA = (pos < 4) ? 4'b0010 : 4'b0000;
      v.expB = (pos < 3) ? 4'b0010 : 4'b0000;
      vecs.push_back(v);
    end

    #2;
    applyReset();

    // A single request is granted on the first edge, and the bus carries
    // that requester's data in the same cycle.
    din0 = 32'hA5C3_7E19;
    applyStimulus(4'b0001, din0);
    checkOutput("r026.grantA", 32'(grantA), 32'h1);
    checkOutput("r026.oeA", 32'(oeA), 32'h1);
    checkOutput("r026.doutA", 32'(doutA), 32'h19);

    // With no requests, the arbiter stays idle.
    applyReset();
    applyStimulus(4'b0000, $urandom);
    applyStimulus(4'b0000, $urandom);
    checkOutput("idle.grantA", 32'(grantA), 32'h0);
    checkOutput("idle.busyB", 32'(busyB), 32'h0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      if (vecs[i].rstBefore) applyReset();
      applyStimulus(vecs[i].req, $urandom);
      checkOutput($sformatf("vec%0d.A", i), 32'(grantA), 32'(vecs[i].expA));
      checkOutput($sformatf("vec%0d.B", i), 32'(grantB), 32'(vecs[i].expB));
    end

    // Owner 2 drops its request after two cycles while requester 0 is
    // waiting. The pointer moves to 3, which is not requesting, so the
    // search wraps to 0.
    applyReset();
    applyStimulus(4'b0100, $urandom);
    checkOutput("r028.own2", 32'(grantA), 32'h4);
    applyStimulus(4'b0101, $urandom);
    checkOutput("r028.hold2", 32'(grantA), 32'h4);
    applyStimulus(4'b0001, $urandom);
    checkOutput("r028.turn", 32'(grantA), 32'h0);
    checkOutput("r028.turnBusy", 32'(busyA), 32'h1);
    applyStimulus(4'b0001, $urandom);
    checkOutput("r028.own0", 32'(grantA), 32'h1);

    // Reset is pulled low between clock edges while the bus is being
    // driven. After release, requester 3 is granted on the next edge.
    applyReset();
    applyStimulus(4'b0001, $urandom);
    applyStimulus(4'b0001, $urandom);
    #2;
    RST_N = 1'b0;
    mA = modelReset();
    mB = modelReset();
    #1;
    checkOutput("r030.oeA", 32'(oeA), 32'h0);
    checkOutput("r030.oeB", 32'(oeB), 32'h0);
    checkOutput("r030.busyA", 32'(busyA), 32'h0);
    checkOutput("r030.doutA", 32'(doutA), 32'h0);
    #2;
    RST_N = 1'b1;
    applyStimulus(4'b1000, $urandom);
    checkOutput("r030.grantA", 32'(grantA), 32'h8);
    checkOutput("r030.grantB", 32'(grantB), 32'h8);

    // Random traffic. Requests mostly hold their level, with an occasional
    // reset mixed in.
    applyReset();
    rq = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      if (n % 500 == 499) applyReset();
      if ($urandom_range(3) == 0) rq = 4'($urandom_range(15));
      applyStimulus(rq, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_bus_arbiter.md
TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 SHALL have parameter: width, 1, data width of the shared tri-state bus.
REQ-002 SHALL have parameter: turnaround, 1, idle cycles with all enables low between bus owners (legal range 1..15).
REQ-003 SHALL have parameter: max_burst, 16, maximum consecutive DRIVE cycles per grant (legal range 1..255).
REQ-004 SHALL have port: CLK  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port: RST_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port: REQ  input  4  per-requester bus request, level-held.
REQ-007 SHALL have port: DIN  input  4*width  requester data; slice k = DIN[(k+1)*width-1 : k*width].
REQ-008 SHALL have port: GRANT  output  4  registered one-hot grant, 0 when no owner.
REQ-009 SHALL have port: OE  output  4  registered output enables for per-requester bus drivers, equal to GRANT.
REQ-010 SHALL have port: BUS_DOUT  output  width  DIN slice of current owner, all-zero when no owner.
REQ-011 SHALL have port: BUSY  output  1  high in DRIVE or TURN state.

Function
REQ-012 SHALL implement states IDLE, DRIVE, TURN with a 2-bit round-robin pointer PTR, burst counter BCNT (8 bits), turnaround counter TCNT (4 bits).
REQ-013 SHALL, in IDLE or at TURN expiry, select the first asserted REQ[k] searching k = PTR, PTR+1, ... mod 4.
REQ-014 SHALL register the selection: REQ sampled at edge n -> GRANT[k]=OE[k]=1 from edge n, state DRIVE, BCNT=1; one-cycle request-to-grant latency.
REQ-015 SHALL stay in IDLE with GRANT=OE=0 when REQ=0.
REQ-016 SHALL drive BUS_DOUT combinationally from registered GRANT and DIN; no registered data stage.
REQ-017 SHALL, in DRIVE, increment BCNT each edge while REQ[k] high and BCNT < max_burst.
REQ-018 SHALL release on the edge where REQ[k]=0 or BCNT==max_burst: GRANT=OE=0, state TURN, TCNT=turnaround, PTR=(k+1) mod 4.
REQ-019 SHALL, in TURN, decrement TCNT each edge; on the edge where TCNT==1 perform REQ-013 selection directly into DRIVE, or go IDLE if REQ=0.
REQ-020 SHALL never assert more than one OE bit, and SHALL never assert any OE bit in TURN or IDLE.
REQ-021 SHALL ignore requests from non-owners during DRIVE and TURN; they are served per REQ-013 afterward.
REQ-022 SHALL allow a sole remaining requester cut off by max_burst to be re-granted after turnaround (pointer wraps to it).
REQ-023 SHALL treat REQ[k] dropping and BCNT==max_burst on the same edge as a single release.

Reset
REQ-024 SHALL, on RST_N low, immediately (asynchronously) clear GRANT, OE, BUSY to 0, state to IDLE, PTR to 0, BCNT and TCNT to 0; BUS_DOUT therefore 0.
REQ-025 SHALL, on reset asserted mid-DRIVE, drop OE in the same cycle without a turnaround, and resume arbitration from PTR=0 on the first edge with RST_N high.

Verification
REQ-026 SHALL verify: reset, then REQ=0001 at edge 1 -> GRANT=0001, OE=0001 after edge 1, BUS_DOUT=DIN slice 0 same cycle.
REQ-027 SHALL verify: REQ=1111 held, turnaround=1, max_burst=4 -> owners 0,1,2,3,0 each 4 DRIVE cycles separated by exactly one cycle with OE=0000.
REQ-028 SHALL verify: owner 2 drops REQ after 2 cycles while REQ[0] high -> TURN 1 cycle, then GRANT=0001, PTR pointed at 3 skipped to 0.
REQ-029 SHALL verify: only REQ[1] held, max_burst=3, turnaround=2 -> OE pattern 0010x3, 0000x2, 0010x3 repeating.
REQ-030 SHALL verify: RST_N pulled low mid-DRIVE between clock edges -> OE=0000 and BUSY=0 before the next edge; after release, REQ=1000 grants requester 3 one edge later.
REQ-031 SHALL verify by assertion across random REQ traffic: OE one-hot-or-zero every cycle, and any owner change is separated by at least turnaround cycles of OE=0000.
